// File: rtl/pulse_pkg.sv
// Shared types for the multi-channel pulse shaper: shaping modes and per-channel states.
package pulse_pkg;

  typedef enum logic [1:0] {
    TRUNCATE    = 2'd0,
    ONESHOT     = 2'd1,
    RETRIGGER   = 2'd2,
    ONESHOT_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } ch_state_e;

  // The spare encoding behaves as one-shot; fold it so channels only ever hold three modes.
  function automatic mode_e norm_mode(input logic [1:0] m);
    mode_e r;
    case (m)
      2'd0:    r = TRUNCATE;
      2'd2:    r = RETRIGGER;
      default: r = ONESHOT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pulse_shaper_ch.sv
// Single pulse-shaper channel: edge detect, IDLE/PULSE/HOLDOFF FSM, width/holdoff down-counter.
//   state   | meaning
//   IDLE    | waiting for a rising edge on i_x
//   PULSE   | o_x high, r_cnt counts remaining pulse cycles
//   HOLDOFF | o_x low, further triggers rejected until r_cnt expires
module pulse_shaper_ch
  import pulse_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_x,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_width,
  input  logic [CNT_W-1:0] i_holdoff,
  output logic             o_x,
  output logic             o_busy,
  output logic             o_miss
);

  ch_state_e        r_state, w_state_nxt;
  mode_e            r_mode, w_mode_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_prev_x;
  logic             r_x, r_busy, r_miss;
  logic             w_rise, w_reload, w_exit, w_miss_nxt;
  logic [CNT_W-1:0] w_cnt_dec, w_width_load;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_mode_nxt   = r_mode;
    w_miss_nxt   = 1'b0;
    w_rise       = i_x & ~r_prev_x;
    w_cnt_dec    = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
    w_width_load = (i_width != '0) ? i_width - 1'b1 : '0;
    // A retrigger reload outranks both expiry and the truncate cut.
    w_reload     = (r_mode == RETRIGGER) && w_rise;
    w_exit       = ((r_mode == TRUNCATE) && !i_x) || ((r_cnt == '0) && !w_reload);

    case (r_state)
      IDLE: begin
        if (w_rise && (i_width != '0)) begin
          w_state_nxt = PULSE;
          w_cnt_nxt   = w_width_load;
          w_mode_nxt  = norm_mode(i_mode);
        end
      end
      PULSE: begin
        if (w_reload) begin
          w_cnt_nxt = w_width_load;
        end else if (w_exit) begin
          if (i_holdoff != '0) begin
            w_state_nxt = HOLDOFF;
            w_cnt_nxt   = i_holdoff - 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
        if (w_rise && (r_mode != TRUNCATE) && (r_mode != RETRIGGER)) begin
          w_miss_nxt = 1'b1;
        end
      end
      HOLDOFF: begin
        w_miss_nxt = w_rise;
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_mode   <= TRUNCATE;
      r_cnt    <= '0;
      r_prev_x <= 1'b0;
      r_x      <= 1'b0;
      r_busy   <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mode   <= w_mode_nxt;
      r_cnt    <= w_cnt_nxt;
      r_prev_x <= i_x;
      r_x      <= (w_state_nxt == PULSE);
      r_busy   <= (w_state_nxt != IDLE);
      r_miss   <= w_miss_nxt;
    end
  end

  assign o_x    = r_x;
  assign o_busy = r_busy;
  assign o_miss = r_miss;

endmodule

// File: rtl/pulse_shaper.sv
// Multi-channel pulse shaper: N_CH independent channels sharing one global configuration.
module pulse_shaper
  import pulse_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [N_CH-1:0]  i_x,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_width,
  input  logic [CNT_W-1:0] i_holdoff,
  output logic [N_CH-1:0]  o_x,
  output logic [N_CH-1:0]  o_busy,
  output logic [N_CH-1:0]  o_miss
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pulse_shaper_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .i_reset  (i_reset),
      .i_x      (i_x[g]),
      .i_mode   (i_mode),
      .i_width  (i_width),
      .i_holdoff(i_holdoff),
      .o_x      (o_x[g]),
      .o_busy   (o_busy[g]),
      .o_miss   (o_miss[g])
    );
  end

endmodule

// File: tb/tb_pulse_shaper.sv
// Scoreboard bench for pulse_shaper: deadline-based reference model feeds an expected-output queue.
module tb_pulse_shaper;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [N_CH-1:0] x;
    logic [N_CH-1:0] busy;
    logic [N_CH-1:0] miss;
  } exp_t;

  logic             clk;
  logic             i_reset;
  logic [N_CH-1:0]  i_x;
  logic [1:0]       i_mode;
  logic [CNT_W-1:0] i_width;
  logic [CNT_W-1:0] i_holdoff;
  logic [N_CH-1:0]  o_x, o_busy, o_miss;

  pulse_shaper #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_x      (i_x),
    .i_mode   (i_mode),
    .i_width  (i_width),
    .i_holdoff(i_holdoff),
    .o_x      (o_x),
    .o_busy   (o_busy),
    .o_miss   (o_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model: each channel remembers the last cycle its pulse is high and the last busy cycle.
  int   cyc = 0;
  int   p_end[N_CH];
  int   h_end[N_CH];
  int   m_mode[N_CH];
  logic m_prev[N_CH];

  logic [1:0]       g_mode = 2'd1;
  logic [CNT_W-1:0] g_w    = 8'd5;
  logic [CNT_W-1:0] g_h    = 8'd0;

  task automatic model_step(input logic [N_CH-1:0] x, input logic rst,
                            input int mode, input int w, input int h);
    exp_t e;
    logic rise;
    e = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rst) begin
        p_end[c]  = -1;
        h_end[c]  = -1;
        m_prev[c] = 1'b0;
      end else begin
        rise = x[c] && !m_prev[c];
        if (cyc <= p_end[c]) begin
          if (m_mode[c] == 2 && rise) p_end[c] = cyc + w;
          else if (m_mode[c] == 0 && !x[c]) p_end[c] = cyc;
          else if (m_mode[c] == 1 && rise) e.miss[c] = 1'b1;
          if (cyc == p_end[c]) h_end[c] = cyc + h;
        end else if (cyc <= h_end[c]) begin
          if (rise) e.miss[c] = 1'b1;
        end else if (rise && w > 0) begin
          p_end[c]  = cyc + w;
          m_mode[c] = (mode == 3) ? 1 : mode;
        end
        m_prev[c] = x[c];
        e.x[c]    = (cyc + 1 <= p_end[c]);
        e.busy[c] = e.x[c] || (cyc + 1 <= h_end[c]);
      end
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic drive(input logic [N_CH-1:0] x, input logic rst);
    @(negedge clk);
    i_x       = x;
    i_reset   = rst;
    i_mode    = g_mode;
    i_width   = g_w;
    i_holdoff = g_h;
    model_step(x, rst, int'(g_mode), int'(g_w), int'(g_h));
  endtask

  task automatic run(input logic [N_CH-1:0] x, input int n);
    repeat (n) drive(x, 1'b0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({o_x, o_busy, o_miss} !== {e.x, e.busy, e.miss}) begin
          n_err++;
          $display("FAIL outputs t=%0t: got x=%b busy=%b miss=%b, want x=%b busy=%b miss=%b",
                   $time, o_x, o_busy, o_miss, e.x, e.busy, e.miss);
        end
      end
    end
  end

  initial begin
    logic [N_CH-1:0] xr;
    int m;
    i_x = '0; i_reset = 1'b1; i_mode = 2'd1; i_width = 8'd5; i_holdoff = 8'd0;
    for (int c = 0; c < N_CH; c++) begin
      p_end[c] = -1; h_end[c] = -1; m_mode[c] = 0; m_prev[c] = 1'b0;
    end

    repeat (3) drive('0, 1'b1);

    // One-shot, W=5, H=0, input high two cycles.
    g_mode = 2'd1; g_w = 8'd5; g_h = 8'd0;
    run(4'b0001, 2); run('0, 6);

    // Truncate: short input cut, long input limited to W.
    g_mode = 2'd0; g_w = 8'd10;
    run(4'b0001, 3);  run('0, 3);
    run(4'b0001, 20); run('0, 3);

    // Retrigger: rises three cycles apart merge into one long pulse.
    g_mode = 2'd2; g_w = 8'd4;
    run(4'b0001, 1); run('0, 2); run(4'b0001, 1); run('0, 8);

    // One-shot with holdoff: rejected rises in pulse and holdoff, then an accepted one.
    g_mode = 2'd1; g_w = 8'd3; g_h = 8'd4;
    run(4'b0001, 1); run('0, 1); run(4'b0001, 1); run('0, 3);
    run(4'b0001, 1); run('0, 2); run(4'b0001, 1); run('0, 6);

    // Zero width is silent; width change mid-pulse does not affect it.
    g_h = 8'd0; g_w = 8'd0;
    run(4'b0001, 2); run('0, 3);
    g_w = 8'd6;
    run(4'b0001, 1);
    g_w = 8'd2;
    run('0, 8);

    // All channels fire, reset lands in the third pulse cycle, input held through release.
    g_w = 8'd6; g_h = 8'd2;
    run('1, 3);
    drive('1, 1'b1);
    run('1, 8); run('0, 4);

    // Randomized traffic, W>=1, occasional reset.
    xr = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        g_mode = 2'($urandom_range(0, 3));
        g_w    = 8'($urandom_range(1, 7));
        g_h    = 8'($urandom_range(0, 5));
      end
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 3) == 0) xr[c] = ~xr[c];
      drive(xr, $urandom_range(0, 299) == 0);
    end

    // Randomized traffic including zero width, without retrigger mode.
    drive(xr, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        m      = int'($urandom_range(0, 2));
        g_mode = (m == 2) ? 2'd3 : 2'(m);
        g_w    = 8'($urandom_range(0, 4));
        g_h    = 8'($urandom_range(0, 3));
      end
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 2) == 0) xr[c] = ~xr[c];
      drive(xr, 1'b0);
    end

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
